// File: rtl/fp_mul_pipe.sv
// ----------------------------------------------------------------------------
// fp_mul_pipe
//   Pipelined IEEE-754-style floating-point multiplier, three register stages
//   (operand decode, mantissa product, normalise/round/pack). Valid/ready on
//   both sides with a single global stall, so bubbles travel with the data and
//   ordering is preserved. Denormal operands are flushed to zero.
//
//   Build option: FP_MUL_RNE_EN
//     defined   -> round-to-nearest-even on guard/sticky bits
//     undefined -> truncation (round toward zero)
//
// Ports
//   CLK        clock, rising edge
//   RESET      synchronous reset, active-high
//   IN_VALID   operand pair valid
//   IN_READY   operands accepted this cycle (low while stalled or in reset)
//   A_OPERAND  operand A, {sign, exp[EXP_W], man[MAN_W]}
//   B_OPERAND  operand B
//   IN_TAG     sideband tag for this operation
//   OUT_VALID  result valid
//   OUT_READY  consumer accepts the result
//   RESULT     product
//   OUT_TAG    tag belonging to RESULT
//   EXCEPTION  an operand was Inf/NaN, RESULT is canonical qNaN
//   OVERFLOW   result saturated to Inf
//   UNDERFLOW  result flushed to signed zero
// ----------------------------------------------------------------------------
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [EXP_W+MAN_W:0]   A_OPERAND,
    input  logic [EXP_W+MAN_W:0]   B_OPERAND,
    input  logic [TAG_W-1:0]       IN_TAG,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [EXP_W+MAN_W:0]   RESULT,
    output logic [TAG_W-1:0]       OUT_TAG,
    output logic                   EXCEPTION,
    output logic                   OVERFLOW,
    output logic                   UNDERFLOW
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int P  = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS    = signed'(XW'((1 << (EXP_W - 1)) - 1));
    localparam logic signed [XW-1:0] EXP_MAX = signed'(XW'((1 << EXP_W) - 1));
    localparam logic signed [XW-1:0] ONE     = signed'(XW'(1));
    localparam logic signed [XW-1:0] ZERO    = '0;

    // Truncation never looks below the mantissa LSB, so the low product bits
    // are only kept when rounding needs them for guard/sticky.
`ifdef FP_MUL_RNE_EN
    localparam int DROP = 0;
`else
    localparam int DROP = MAN_W;
`endif

    logic stall, en;
    assign stall    = OUT_VALID & ~OUT_READY;
    assign en       = ~stall;
    assign IN_READY = ~stall & ~RESET;

    // ---------------- stage 1: decode ----------------
    logic [EXP_W-1:0] a_exp, b_exp;
    assign a_exp = A_OPERAND[W-2 -: EXP_W];
    assign b_exp = B_OPERAND[W-2 -: EXP_W];

    logic                   s1_valid, s1_sign, s1_exc, s1_zero;
    logic signed [XW-1:0]   s1_exp;
    logic [MAN_W:0]         s1_man_a, s1_man_b;
    logic [TAG_W-1:0]       s1_tag;

    // ---------------- stage 2: product ----------------
    logic                   s2_valid, s2_sign, s2_exc, s2_zero;
    logic signed [XW-1:0]   s2_exp;
    logic [P-1:DROP]        s2_prod;
    logic [TAG_W-1:0]       s2_tag;
    logic [P-1:0]           prod_full;

    assign prod_full = s1_man_a * s1_man_b;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= IN_VALID;
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (en) begin
            s1_sign  <= A_OPERAND[W-1] ^ B_OPERAND[W-1];
            s1_exp   <= signed'({2'b00, a_exp}) + signed'({2'b00, b_exp}) - BIAS;
            s1_man_a <= {1'b1, A_OPERAND[MAN_W-1:0]};
            s1_man_b <= {1'b1, B_OPERAND[MAN_W-1:0]};
            s1_exc   <= (&a_exp) | (&b_exp);
            s1_zero  <= (a_exp == '0) | (b_exp == '0);
            s1_tag   <= IN_TAG;

            s2_sign  <= s1_sign;
            s2_exp   <= s1_exp;
            s2_prod  <= (P-DROP)'(prod_full >> DROP);
            s2_exc   <= s1_exc;
            s2_zero  <= s1_zero;
            s2_tag   <= s1_tag;
        end
    end

    // ---------------- stage 3: normalise, round, pack ----------------
    logic signed [XW-1:0]   norm_exp, fin_exp;
    logic [MAN_W-1:0]       man_t;
    logic [MAN_W:0]         man_r;
    logic                   round_up;
    logic [W-1:0]           res_c;
    logic                   exc_c, ovf_c, unf_c;
`ifdef FP_MUL_RNE_EN
    logic                   guard, sticky;
`endif

    always_comb begin
        if (s2_prod[P-1]) begin
            norm_exp = s2_exp + ONE;
            man_t    = s2_prod[P-2 -: MAN_W];
        end else begin
            norm_exp = s2_exp;
            man_t    = s2_prod[P-3 -: MAN_W];
        end
`ifdef FP_MUL_RNE_EN
        if (s2_prod[P-1]) begin
            guard  = s2_prod[P-2-MAN_W];
            sticky = |s2_prod[P-3-MAN_W:0];
        end else begin
            guard  = s2_prod[P-3-MAN_W];
            sticky = |s2_prod[P-4-MAN_W:0];
        end
        round_up = guard & (sticky | man_t[0]);
`else
        round_up = 1'b0;
`endif
        // A carry out of the mantissa leaves it all-zero: 1.11..1 + ulp = 10.0
        man_r   = {1'b0, man_t} + (MAN_W+1)'(round_up);
        fin_exp = norm_exp + (man_r[MAN_W] ? ONE : ZERO);

        res_c = '0;
        exc_c = 1'b0;
        ovf_c = 1'b0;
        unf_c = 1'b0;
        if (s2_exc) begin
            exc_c = 1'b1;
            res_c = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (s2_zero) begin
            res_c = {s2_sign, {(W-1){1'b0}}};
        end else if (fin_exp >= EXP_MAX) begin
            ovf_c = 1'b1;
            res_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (fin_exp <= ZERO) begin
            unf_c = 1'b1;
            res_c = {s2_sign, {(W-1){1'b0}}};
        end else begin
            res_c = {s2_sign, fin_exp[EXP_W-1:0], man_r[MAN_W-1:0]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            OUT_VALID <= 1'b0;
            RESULT    <= '0;
            OUT_TAG   <= '0;
            EXCEPTION <= 1'b0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else if (en) begin
            OUT_VALID <= s2_valid;
            RESULT    <= res_c;
            OUT_TAG   <= s2_tag;
            EXCEPTION <= exc_c;
            OVERFLOW  <= ovf_c;
            UNDERFLOW <= unf_c;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// ----------------------------------------------------------------------------
// tb_fp_mul_pipe
//   Directed bench for fp_mul_pipe at single precision (EXP_W=8, MAN_W=23):
//   reset state, latency, special-case priority, rounding, stall/backpressure
//   ordering, and reset with operations in flight.
// ----------------------------------------------------------------------------
module tb_fp_mul_pipe;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] A_OPERAND;
    logic [31:0] B_OPERAND;
    logic [3:0]  IN_TAG;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] RESULT;
    logic [3:0]  OUT_TAG;
    logic        EXCEPTION;
    logic        OVERFLOW;
    logic        UNDERFLOW;

    always #5 CLK = ~CLK;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A_OPERAND (A_OPERAND),
        .B_OPERAND (B_OPERAND),
        .IN_TAG    (IN_TAG),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RESULT    (RESULT),
        .OUT_TAG   (OUT_TAG),
        .EXCEPTION (EXCEPTION),
        .OVERFLOW  (OVERFLOW),
        .UNDERFLOW (UNDERFLOW)
    );

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_EXC  = 3'b100;
    localparam logic [2:0] F_OVF  = 3'b010;
    localparam logic [2:0] F_UNF  = 3'b001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op into an idle pipe, wait (bounded) for it, check everything.
    task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag, input logic [31:0] exp_res,
                           input logic [2:0] exp_flags);
        int lat;
        bit got;
        @(negedge CLK);
        A_OPERAND = a;
        B_OPERAND = b;
        IN_TAG    = tag;
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        #1;
        check({name, " in_ready"}, 32'(IN_READY), 32'd1);
        @(posedge CLK);
        lat = 1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        got = 1'b0;
        while (!got && lat < 10) begin
            if (OUT_VALID) got = 1'b1;
            else begin
                @(posedge CLK);
                lat++;
                @(negedge CLK);
            end
        end
        check({name, " latency"}, 32'(lat), 32'd3);
        check({name, " result"}, RESULT, exp_res);
        check({name, " tag"}, 32'(OUT_TAG), 32'(tag));
        check({name, " flags"}, 32'({EXCEPTION, OVERFLOW, UNDERFLOW}), 32'(exp_flags));
        @(posedge CLK);
    endtask

    logic [31:0] a_tab   [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                 32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [31:0] exp_tab [6] = '{32'h40000000, 32'h40800000, 32'h40C00000,
                                 32'h41000000, 32'h41200000, 32'h41400000};

    initial begin
        int issued, delivered, stall_left, cyc, stray;
        bit seen, held_ok;
        logic [31:0] held;

        RESET     = 1'b1;
        IN_VALID  = 1'b0;
        A_OPERAND = '0;
        B_OPERAND = '0;
        IN_TAG    = '0;
        OUT_READY = 1'b1;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset out_valid", 32'(OUT_VALID), 32'd0);
        check("reset in_ready", 32'(IN_READY), 32'd0);
        check("reset result", RESULT, 32'd0);
        check("reset tag", 32'(OUT_TAG), 32'd0);
        check("reset flags", 32'({EXCEPTION, OVERFLOW, UNDERFLOW}), 32'd0);
        RESET = 1'b0;
        #1;
        check("post-reset in_ready", 32'(IN_READY), 32'd1);

        run_one("5x5",      32'h40A00000, 32'h40A00000, 4'd1, 32'h41C80000, F_NONE);
        run_one("ovf",      32'h7F000000, 32'h7F000000, 4'd2, 32'h7F800000, F_OVF);
        run_one("unf",      32'h00800000, 32'h00800000, 4'd3, 32'h00000000, F_UNF);
        run_one("nan",      32'h7FC00000, 32'h3F800000, 4'd4, 32'h7FC00000, F_EXC);
        run_one("zero",     32'h00000000, 32'hC0000000, 4'd5, 32'h80000000, F_NONE);
        run_one("inf_zero", 32'h7F800000, 32'h00000000, 4'd6, 32'h7FC00000, F_EXC);
        run_one("neg",      32'hC0400000, 32'h40000000, 4'd7, 32'hC0C00000, F_NONE);
`ifdef FP_MUL_RNE_EN
        run_one("round",    32'h3FC00001, 32'h3FC00001, 4'd8, 32'h40100002, F_NONE);
`else
        run_one("round",    32'h3FC00001, 32'h3FC00001, 4'd8, 32'h40100001, F_NONE);
`endif

        // Back-to-back stream with a 5-cycle consumer stall
        issued = 0; delivered = 0; stall_left = 0; cyc = 0;
        seen = 1'b0; held_ok = 1'b0; held = '0;
        while (delivered < 6 && cyc < 60) begin
            @(negedge CLK);
            cyc++;
            if (OUT_VALID && !seen) begin
                seen = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                OUT_READY = 1'b0;
                stall_left--;
            end else begin
                OUT_READY = 1'b1;
            end
            if (issued < 6) begin
                IN_VALID  = 1'b1;
                A_OPERAND = a_tab[issued];
                B_OPERAND = 32'h40000000;
                IN_TAG    = issued[3:0];
            end else begin
                IN_VALID = 1'b0;
            end
            #1;
            if (!OUT_READY) begin
                check("stall in_ready", 32'(IN_READY), 32'd0);
                if (held_ok) check("stall result held", RESULT, held);
                else begin
                    held    = RESULT;
                    held_ok = 1'b1;
                end
            end
            if (IN_VALID && IN_READY) issued++;
            if (OUT_VALID && OUT_READY) begin
                check("stream tag", 32'(OUT_TAG), 32'(delivered));
                check("stream result", RESULT, exp_tab[delivered]);
                delivered++;
            end
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        check("stream delivered", 32'(delivered), 32'd6);
        check("stream issued", 32'(issued), 32'd6);
        stray = 0;
        repeat (5) begin
            @(negedge CLK);
            if (OUT_VALID) stray++;
        end
        check("stream no duplicates", 32'(stray), 32'd0);

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            IN_VALID  = 1'b1;
            A_OPERAND = 32'h40400000;
            B_OPERAND = 32'h40000000;
            IN_TAG    = 4'(9 + i);
            @(posedge CLK);
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
        RESET    = 1'b1;
        #1;
        check("mid-reset in_ready", 32'(IN_READY), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        check("after reset out_valid", 32'(OUT_VALID), 32'd0);
        check("after reset result", RESULT, 32'd0);
        stray = 0;
        repeat (6) begin
            @(negedge CLK);
            if (OUT_VALID) stray++;
        end
        check("after reset no stale", 32'(stray), 32'd0);
        run_one("post-reset op", 32'h40400000, 32'h40400000, 4'd12, 32'h41100000, F_NONE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
